sdram_burst_responder: RTL and testbench

SDRAM_BURST_RESPONDER -- requirements
Module: sdram_burst_responder

---
 rtl/sdram_burst_pkg.sv | 18 +
 rtl/sdram_halfword_packer.sv | 45 ++++
 rtl/sdram_burst_responder.sv | 120 ++++++++++++
 tb/tb_sdram_burst_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_burst_pkg.sv
// Shared types and sizing for the SDRAM burst read responder.
package sdram_burst_pkg;

    localparam int unsigned BL                  = 2;
    localparam int unsigned DEF_MAX_OUTSTANDING = 4;
    localparam int unsigned MEM_ADDR_W          = 25;
    localparam int unsigned LEN_W               = 11;
    localparam int unsigned HW_W                = 16;
    localparam int unsigned BEAT_W              = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sdram_halfword_packer.sv
// Turns the returned halfword stream into 16-bit or packed 32-bit beats.
module sdram_halfword_packer
    import sdram_burst_pkg::*;
(
    input  logic              clk_sdram,
    input  logic              reset_n,
    input  logic              hw_valid,
    input  logic [HW_W-1:0]   hw_data,
    input  logic              mode_32bit,
    output logic              second_hw_c,
    output logic [BEAT_W-1:0] beat_data,
    output logic              beat_valid
);

    logic            hw_toggle;
    logic [HW_W-1:0] first_hw;

    // Toggle is 1 on the second halfword of each BL=2 command.
    assign second_hw_c = hw_valid && hw_toggle;

    always_ff @(posedge clk_sdram or negedge reset_n) begin
        if (!reset_n) begin
            hw_toggle  <= 1'b0;
            first_hw   <= '0;
            beat_data  <= '0;
            beat_valid <= 1'b0;
        end else begin
            beat_valid <= 1'b0;
            if (hw_valid) begin
                hw_toggle <= ~hw_toggle;
                if (!hw_toggle) begin
                    first_hw <= hw_data;
                end
                if (!mode_32bit) begin
                    beat_data  <= {{(BEAT_W-HW_W){1'b0}}, hw_data};
                    beat_valid <= 1'b1;
                end else if (hw_toggle) begin
                    beat_data  <= {hw_data, first_hw};
                    beat_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sdram_burst_responder.sv
// Splits a burst request into BL=2 SDRAM READ commands with bounded outstanding
// reads and returns the data as 16- or 32-bit beats.
module sdram_burst_responder
    import sdram_burst_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int unsigned ADDR_W          = MEM_ADDR_W
) (
    input  logic              clk_sdram,
    input  logic              reset_n,
    input  logic              burst_rd,
    input  logic [ADDR_W-1:0] burst_addr,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              burst_32bit,
    output logic [BEAT_W-1:0] burst_data,
    output logic              burst_data_valid,
    output logic              burst_data_done,
    output logic              busy,
    output logic              burst_err,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [HW_W-1:0]   mem_rdata,
    input  logic              mem_rvalid
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    state_e            state, state_nxt;
    logic [LEN_W-1:0]  cmds_left, cmds_left_nxt;
    logic [OUT_W-1:0]  outstanding, outstanding_nxt;
    logic              mode_q, mode_nxt;
    logic              mem_rd_nxt, busy_nxt, done_nxt, err_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              accept_c, ack_c, rvalid_ok_c, second_hw_c;

    assign accept_c    = burst_rd && (state == IDLE);
    assign ack_c       = mem_rd && mem_ack;
    // Returns with nothing outstanding are strays and never reach the packer.
    assign rvalid_ok_c = mem_rvalid && (outstanding != '0);
    assign outstanding_nxt = outstanding + OUT_W'(ack_c) - OUT_W'(second_hw_c);

    always_ff @(posedge clk_sdram or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (burst_rd) state_nxt = (burst_len == '0) ? DONE : ISSUE;
            ISSUE:   if (ack_c && (cmds_left == LEN_W'(1))) state_nxt = DRAIN;
            // Looking at the next count lets done land one cycle after the last beat.
            DRAIN:   if (outstanding_nxt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        cmds_left_nxt = cmds_left;
        mode_nxt      = mode_q;
        if (accept_c) begin
            mode_nxt      = burst_32bit;
            cmds_left_nxt = burst_len;
            mem_addr_nxt  = burst_addr;
            mem_rd_nxt    = (burst_len != '0);
        end else if (state == ISSUE) begin
            if (ack_c) begin
                cmds_left_nxt = cmds_left - LEN_W'(1);
                mem_addr_nxt  = mem_addr + ADDR_W'(BL);
            end
            mem_rd_nxt = (mem_rd && !mem_ack) ||
                         ((cmds_left_nxt != '0) &&
                          (outstanding_nxt < OUT_W'(MAX_OUTSTANDING)));
        end
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == DONE);
        err_nxt  = (burst_rd && !accept_c) || (mem_rvalid && !rvalid_ok_c);
    end

    always_ff @(posedge clk_sdram or negedge reset_n) begin
        if (!reset_n) begin
            mem_rd          <= 1'b0;
            mem_addr        <= '0;
            cmds_left       <= '0;
            outstanding     <= '0;
            mode_q          <= 1'b0;
            busy            <= 1'b0;
            burst_data_done <= 1'b0;
            burst_err       <= 1'b0;
        end else begin
            mem_rd          <= mem_rd_nxt;
            mem_addr        <= mem_addr_nxt;
            cmds_left       <= cmds_left_nxt;
            outstanding     <= outstanding_nxt;
            mode_q          <= mode_nxt;
            busy            <= busy_nxt;
            burst_data_done <= done_nxt;
            burst_err       <= err_nxt;
        end
    end

    sdram_halfword_packer u_packer (
        .clk_sdram   (clk_sdram),
        .reset_n     (reset_n),
        .hw_valid    (rvalid_ok_c),
        .hw_data     (mem_rdata),
        .mode_32bit  (mode_q),
        .second_hw_c (second_hw_c),
        .beat_data   (burst_data),
        .beat_valid  (burst_data_valid)
    );

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Directed bench for sdram_burst_responder with an in-order SDRAM return model.
module tb_sdram_burst_responder;

    logic        clk_sdram = 1'b0;
    logic        reset_n;
    logic        burst_rd;
    logic [24:0] burst_addr;
    logic [10:0] burst_len;
    logic        burst_32bit;
    logic [31:0] burst_data;
    logic        burst_data_valid;
    logic        burst_data_done;
    logic        busy;
    logic        burst_err;
    logic        mem_rd;
    logic [24:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;

    sdram_burst_responder dut (
        .clk_sdram        (clk_sdram),
        .reset_n          (reset_n),
        .burst_rd         (burst_rd),
        .burst_addr       (burst_addr),
        .burst_len        (burst_len),
        .burst_32bit      (burst_32bit),
        .burst_data       (burst_data),
        .burst_data_valid (burst_data_valid),
        .burst_data_done  (burst_data_done),
        .busy             (busy),
        .burst_err        (burst_err),
        .mem_rd           (mem_rd),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .mem_rvalid       (mem_rvalid)
    );

    always #5 clk_sdram = ~clk_sdram;

    typedef struct {
        int unsigned due;
        logic [15:0] data;
        bit          second;
    } hw_t;

    hw_t         hw_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int unsigned cyc = 0;
    int          beat_cnt, ack_cnt, done_cnt;
    int unsigned done_cyc, last_valid_cyc, sec_cyc, ack5_cyc, stall_until;
    logic [24:0] base, exp_addr;
    logic        mode32;
    logic [31:0] last_beat;

    function automatic logic [15:0] hw_lo(input logic [24:0] a);
        return a[15:0] + 16'h1111;
    endfunction

    function automatic logic [15:0] hw_hi(input logic [24:0] a);
        return a[15:0] ^ 16'hFFFF;
    endfunction

    function automatic logic [31:0] exp_beat(input int b);
        logic [24:0] a;
        if (mode32) begin
            a = base + 25'(2 * b);
            return {hw_hi(a), hw_lo(a)};
        end
        a = base + 25'(2 * (b / 2));
        return (b % 2 == 0) ? {16'h0, hw_lo(a)} : {16'h0, hw_hi(a)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs on the falling edge, then run the memory model.
    task automatic tick();
        hw_t e;
        @(negedge clk_sdram);
        cyc++;
        if (burst_data_done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_no_beat", 32'(burst_data_valid), 32'd0);
        end
        if (burst_data_valid) begin
            chk("beat_data", burst_data, exp_beat(beat_cnt));
            beat_cnt++;
            last_valid_cyc = cyc;
            last_beat = burst_data;
        end
        if (mem_rd && mem_ack) begin
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            e.due = cyc + 3; e.data = hw_lo(exp_addr); e.second = 1'b0;
            hw_q.push_back(e);
            e.due = cyc + 4; e.data = hw_hi(exp_addr); e.second = 1'b1;
            hw_q.push_back(e);
            exp_addr = exp_addr + 25'd2;
            if (ack_cnt == 4) ack5_cyc = cyc;
            ack_cnt++;
        end
        mem_rvalid = 1'b0;
        if (cyc >= stall_until && hw_q.size() > 0 && hw_q[0].due <= cyc) begin
            e = hw_q.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata = e.data;
            if (e.second && sec_cyc == 0) sec_cyc = cyc;
        end
    endtask

    task automatic start_burst(input logic [24:0] a, input logic [10:0] l, input logic m32);
        base = a; mode32 = m32; exp_addr = a;
        beat_cnt = 0; ack_cnt = 0; done_cnt = 0; sec_cyc = 0; ack5_cyc = 0;
        burst_addr = a; burst_len = l; burst_32bit = m32; burst_rd = 1'b1;
        tick();
        burst_rd = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done_cnt), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_rd"},   32'(mem_rd), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_data"},     burst_data, 32'd0);
        chk({tag, "_valid"},    32'(burst_data_valid), 32'd0);
        chk({tag, "_done"},     32'(burst_data_done), 32'd0);
        chk({tag, "_busy"},     32'(busy), 32'd0);
        chk({tag, "_err"},      32'(burst_err), 32'd0);
    endtask

    initial begin
        int n;
        reset_n = 1'b0; burst_rd = 1'b0; burst_addr = '0; burst_len = '0;
        burst_32bit = 1'b0; mem_ack = 1'b1; mem_rdata = '0; mem_rvalid = 1'b0;
        base = '0; exp_addr = '0; mode32 = 1'b0; last_beat = '0; stall_until = 0;
        beat_cnt = 0; ack_cnt = 0; done_cnt = 0;
        done_cyc = 0; last_valid_cyc = 0; sec_cyc = 0; ack5_cyc = 0;
        repeat (3) tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // 80-command 32-bit burst
        start_burst(25'h1000, 11'd80, 1'b1);
        chk("b1_busy", 32'(busy), 32'd1);
        chk("b1_first_rd", 32'(mem_rd), 32'd1);
        wait_done(1000);
        chk("b1_beats", 32'(beat_cnt), 32'd80);
        chk("b1_acks", 32'(ack_cnt), 32'd80);
        chk("b1_done_after_last", done_cyc, last_valid_cyc + 1);
        repeat (3) tick();
        chk("b1_one_done", 32'(done_cnt), 32'd1);
        chk("b1_idle_busy", 32'(busy), 32'd0);
        chk("b1_data_hold", burst_data, last_beat);

        // 3-command 16-bit burst
        start_burst(25'h2000, 11'd3, 1'b0);
        wait_done(200);
        chk("b2_beats", 32'(beat_cnt), 32'd6);
        chk("b2_done_after_last", done_cyc, last_valid_cyc + 1);
        tick();

        // Returns withheld for 20 cycles
        stall_until = cyc + 20;
        start_burst(25'h3000, 11'd6, 1'b1);
        repeat (3) tick();
        tick();
        chk("bp_rd_dropped", 32'(mem_rd), 32'd0);
        chk("bp_acks", 32'(ack_cnt), 32'd4);
        repeat (10) tick();
        chk("bp_rd_still_low", 32'(mem_rd), 32'd0);
        wait_done(300);
        chk("bp_reissue", ack5_cyc, sec_cyc + 1);
        chk("bp_beats", 32'(beat_cnt), 32'd6);
        stall_until = 0;
        tick();

        // Zero length, with a second request landing as DONE returns to IDLE
        base = 25'h0; exp_addr = 25'h0; beat_cnt = 0; ack_cnt = 0; done_cnt = 0;
        burst_addr = 25'h0ABC; burst_len = 11'd0; burst_32bit = 1'b1; burst_rd = 1'b1;
        tick();
        chk("z_busy", 32'(busy), 32'd1);
        chk("z_no_rd", 32'(mem_rd), 32'd0);
        chk("z_no_done_yet", 32'(burst_data_done), 32'd0);
        burst_len = 11'd5;
        tick();
        burst_rd = 1'b0;
        chk("z_done", 32'(burst_data_done), 32'd1);
        chk("z_busy_low", 32'(busy), 32'd0);
        chk("z_late_rd_err", 32'(burst_err), 32'd1);
        tick();
        chk("z_done_one_cycle", 32'(burst_data_done), 32'd0);
        chk("z_late_rd_ignored", 32'(mem_rd), 32'd0);
        repeat (3) tick();
        chk("z_done_count", 32'(done_cnt), 32'd1);
        chk("z_no_beats", 32'(beat_cnt), 32'd0);
        chk("z_no_acks", 32'(ack_cnt), 32'd0);

        // Request while busy, then a stray return in IDLE
        start_burst(25'h4000, 11'd8, 1'b1);
        repeat (3) tick();
        burst_addr = 25'h7777; burst_len = 11'd2; burst_rd = 1'b1;
        tick();
        burst_rd = 1'b0;
        chk("pe_busy_rd_err", 32'(burst_err), 32'd1);
        wait_done(300);
        chk("pe_beats", 32'(beat_cnt), 32'd8);
        chk("pe_acks", 32'(ack_cnt), 32'd8);
        repeat (2) tick();
        mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        chk("pe_stray_err", 32'(burst_err), 32'd1);
        chk("pe_stray_no_beat", 32'(burst_data_valid), 32'd0);
        tick();
        chk("pe_stray_err_pulse", 32'(burst_err), 32'd0);
        chk("pe_stray_beats", 32'(beat_cnt), 32'd8);

        // Reset in the middle of an 80-command burst
        start_burst(25'h5000, 11'd80, 1'b1);
        n = 0;
        while (beat_cnt < 10 && n < 500) begin
            tick();
            n++;
        end
        chk("rst_reached_beat10", 32'(beat_cnt), 32'd10);
        reset_n = 1'b0;
        hw_q.delete();
        #1;
        chk_all_zero("midrst");
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);

        // Recovery burst that also wraps the top of the address space
        start_burst(25'h1FF_FFFC, 11'd4, 1'b1);
        wait_done(200);
        chk("wrap_beats", 32'(beat_cnt), 32'd4);
        chk("wrap_acks", 32'(ack_cnt), 32'd4);
        chk("wrap_done_after_last", done_cyc, last_valid_cyc + 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
